// File: rtl/pong_ball_engine_pkg.sv
// pong_pkg: shared types and screen defaults for the Pong ball engine.
//   ball_state_t : engine state (IDLE, SERVE, PLAY, GAME_OVER)
//   dir_t        : axis direction; DIR_POS = right / down, DIR_NEG = left / up
//   POS_W        : width of the screen coordinate buses
//   CALC_W       : signed width used for move arithmetic, so that moves past
//                  the left/top edge stay representable as negative values
//   SPEED_W      : x-speed register width (SPEED_MAX must fit)
package pong_pkg;

   localparam int H_ACTIVE_DEF = 800;
   localparam int V_ACTIVE_DEF = 600;

   localparam int POS_W   = 11;
   localparam int CALC_W  = 12;
   localparam int SPEED_W = 4;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      SERVE     = 2'd1,
      PLAY      = 2'd2,
      GAME_OVER = 2'd3
   } ball_state_t;

   typedef enum logic {
      DIR_POS = 1'b0,
      DIR_NEG = 1'b1
   } dir_t;

endpackage

// File: rtl/pong_ball_engine_if.sv
// pong_ball_engine_if: bundle between the paddle controllers / frame timing
// and the ball engine, plus the engine results consumed by the draw stages.
//   frame_tick, start     : control pulses into the engine
//   pad_l_y, pad_r_y      : paddle top y coordinates
//   xpos, ypos            : ball top-left corner
//   score_l, score_r      : player scores
//   game_over, winner     : end-of-game flag and winning side (0 left, 1 right)
// master drives the inputs and observes the results; slave is the engine.
interface pong_ball_engine_if
   import pong_pkg::*;
#(
   parameter int SCORE_W = 4
);
   logic               frame_tick;
   logic               start;
   logic [POS_W-1:0]   pad_l_y;
   logic [POS_W-1:0]   pad_r_y;
   logic [POS_W-1:0]   xpos;
   logic [POS_W-1:0]   ypos;
   logic [SCORE_W-1:0] score_l;
   logic [SCORE_W-1:0] score_r;
   logic               game_over;
   logic               winner;

   modport master (
      output frame_tick, start, pad_l_y, pad_r_y,
      input  xpos, ypos, score_l, score_r, game_over, winner
   );

   modport slave (
      input  frame_tick, start, pad_l_y, pad_r_y,
      output xpos, ypos, score_l, score_r, game_over, winner
   );

endinterface

// File: rtl/pong_ball_engine_step.sv
// pong_ball_step: purely combinational single-move evaluation of the ball.
//   in : xpos, ypos, dx, dy, speed, pad_l_y, pad_r_y
//   out: xpos_nxt, ypos_nxt, dx_nxt, dy_nxt, speed_nxt  (candidate next state)
//        hit_l, hit_r     : ball meets the left / right paddle face this move
//        point_l, point_r : left / right player scores (ball left the field)
// On a point the position outputs are meaningless; the caller recentres.
module pong_ball_step
   import pong_pkg::*;
#(
   parameter int H_ACTIVE   = H_ACTIVE_DEF,
   parameter int V_ACTIVE   = V_ACTIVE_DEF,
   parameter int BALL_SIZE  = 16,
   parameter int PAD_W      = 10,
   parameter int PAD_H      = 80,
   parameter int PAD_L_X    = 20,
   parameter int PAD_R_X    = 770,
   parameter int SPEED_INIT = 2,
   parameter int SPEED_MAX  = 8
) (
   input  logic [POS_W-1:0]   xpos,
   input  logic [POS_W-1:0]   ypos,
   input  dir_t               dx,
   input  dir_t               dy,
   input  logic [SPEED_W-1:0] speed,
   input  logic [POS_W-1:0]   pad_l_y,
   input  logic [POS_W-1:0]   pad_r_y,
   output logic [POS_W-1:0]   xpos_nxt,
   output logic [POS_W-1:0]   ypos_nxt,
   output dir_t               dx_nxt,
   output dir_t               dy_nxt,
   output logic [SPEED_W-1:0] speed_nxt,
   output logic               hit_l,
   output logic               hit_r,
   output logic               point_l,
   output logic               point_r
);

   localparam logic signed [CALC_W-1:0] ZERO   = '0;
   localparam logic signed [CALC_W-1:0] X_HI   = CALC_W'(H_ACTIVE - BALL_SIZE);
   localparam logic signed [CALC_W-1:0] Y_HI   = CALC_W'(V_ACTIVE - BALL_SIZE);
   localparam logic signed [CALC_W-1:0] L_FACE = CALC_W'(PAD_L_X + PAD_W);
   localparam logic signed [CALC_W-1:0] R_FACE = CALC_W'(PAD_R_X - BALL_SIZE);
   localparam logic signed [CALC_W-1:0] Y_STEP = CALC_W'(SPEED_INIT);

   function automatic logic [SPEED_W-1:0] speed_up(input logic [SPEED_W-1:0] s);
      if (s >= SPEED_W'(SPEED_MAX)) return SPEED_W'(SPEED_MAX);
      return s + 1'b1;
   endfunction

   logic signed [CALC_W-1:0] xs, ys, xn, yn, spd;
   logic        [CALC_W-1:0] ball_bot, pad_l_bot, pad_r_bot;
   logic                     overlap_l, overlap_r;

   always_comb begin
      xs  = signed'({1'b0, xpos});
      ys  = signed'({1'b0, ypos});
      spd = signed'(CALC_W'(speed));

      xn = (dx == DIR_POS) ? xs + spd : xs - spd;
      yn = (dy == DIR_POS) ? ys + Y_STEP : ys - Y_STEP;

      // Overlap is judged on the pre-move y, in unsigned 12 bits so that
      // pad_y + PAD_H cannot overflow.
      ball_bot  = {1'b0, ypos} + CALC_W'(BALL_SIZE);
      pad_l_bot = {1'b0, pad_l_y} + CALC_W'(PAD_H);
      pad_r_bot = {1'b0, pad_r_y} + CALC_W'(PAD_H);
      overlap_l = (ball_bot > {1'b0, pad_l_y}) && ({1'b0, ypos} < pad_l_bot);
      overlap_r = (ball_bot > {1'b0, pad_r_y}) && ({1'b0, ypos} < pad_r_bot);

      // A hit needs the ball to start on the field side of the face and
      // reach or cross it during this move.
      hit_l = (dx == DIR_NEG) && (xs >= L_FACE) && (xn <= L_FACE) && overlap_l;
      hit_r = (dx == DIR_POS) && (xs <= R_FACE) && (xn >= R_FACE) && overlap_r;

      point_r = !hit_l && !hit_r && (xn <= ZERO);
      point_l = !hit_l && !hit_r && (xn >= X_HI);

      ypos_nxt = yn[POS_W-1:0];
      dy_nxt   = dy;
      if (yn <= ZERO) begin
         ypos_nxt = '0;
         dy_nxt   = DIR_POS;
      end else if (yn >= Y_HI) begin
         ypos_nxt = Y_HI[POS_W-1:0];
         dy_nxt   = DIR_NEG;
      end

      xpos_nxt  = xn[POS_W-1:0];
      dx_nxt    = dx;
      speed_nxt = speed;
      if (hit_l) begin
         xpos_nxt  = L_FACE[POS_W-1:0];
         dx_nxt    = DIR_POS;
         speed_nxt = speed_up(speed);
      end else if (hit_r) begin
         xpos_nxt  = R_FACE[POS_W-1:0];
         dx_nxt    = DIR_NEG;
         speed_nxt = speed_up(speed);
      end
   end

endmodule

// File: rtl/pong_ball_engine.sv
// pong_ball_engine: two-player Pong ball engine. Moves the ball once per
// frame tick, applies wall/paddle bounces via pong_ball_step, keeps scores
// and runs the IDLE -> SERVE -> PLAY -> GAME_OVER state machine.
//   clk  : system clock
//   rst  : asynchronous active-low reset
//   bus  : pong_ball_engine_if.slave (frame_tick, start, paddle y inputs;
//          ball position, scores, game_over, winner outputs)
// All outputs are registered; a frame_tick updates them on the next edge.
module pong_ball_engine
   import pong_pkg::*;
#(
   parameter int H_ACTIVE    = H_ACTIVE_DEF,
   parameter int V_ACTIVE    = V_ACTIVE_DEF,
   parameter int BALL_SIZE   = 16,
   parameter int PAD_W       = 10,
   parameter int PAD_H       = 80,
   parameter int PAD_L_X     = 20,
   parameter int PAD_R_X     = 770,
   parameter int SPEED_INIT  = 2,
   parameter int SPEED_MAX   = 8,
   parameter int SCORE_W     = 4,
   parameter int SCORE_MAX   = 5,
   parameter int SERVE_DELAY = 60
) (
   input  logic              clk,
   input  logic              rst,
   pong_ball_engine_if.slave bus
);

   localparam logic [POS_W-1:0]   XC        = POS_W'((H_ACTIVE - BALL_SIZE) / 2);
   localparam logic [POS_W-1:0]   YC        = POS_W'((V_ACTIVE - BALL_SIZE) / 2);
   localparam int                 CNT_W     = $clog2(SERVE_DELAY + 1);
   localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(SERVE_DELAY - 1);
   localparam logic [SCORE_W-1:0] SCORE_END = SCORE_W'(SCORE_MAX);
   localparam logic [SPEED_W-1:0] SPD_SERVE = SPEED_W'(SPEED_INIT);

   ball_state_t        state_q, state_d;
   logic [POS_W-1:0]   xpos_q, xpos_d, ypos_q, ypos_d;
   dir_t               dx_q, dx_d, dy_q, dy_d;
   logic [SPEED_W-1:0] speed_q, speed_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [SCORE_W-1:0] score_l_q, score_l_d, score_r_q, score_r_d;
   logic               game_over_q, game_over_d;
   logic               winner_q, winner_d;

   logic [POS_W-1:0]   step_x, step_y;
   dir_t               step_dx, step_dy;
   logic [SPEED_W-1:0] step_speed;
   logic               hit_l, hit_r, point_l, point_r;

   pong_ball_step #(
      .H_ACTIVE   (H_ACTIVE),
      .V_ACTIVE   (V_ACTIVE),
      .BALL_SIZE  (BALL_SIZE),
      .PAD_W      (PAD_W),
      .PAD_H      (PAD_H),
      .PAD_L_X    (PAD_L_X),
      .PAD_R_X    (PAD_R_X),
      .SPEED_INIT (SPEED_INIT),
      .SPEED_MAX  (SPEED_MAX)
   ) u_step (
      .xpos      (xpos_q),
      .ypos      (ypos_q),
      .dx        (dx_q),
      .dy        (dy_q),
      .speed     (speed_q),
      .pad_l_y   (bus.pad_l_y),
      .pad_r_y   (bus.pad_r_y),
      .xpos_nxt  (step_x),
      .ypos_nxt  (step_y),
      .dx_nxt    (step_dx),
      .dy_nxt    (step_dy),
      .speed_nxt (step_speed),
      .hit_l     (hit_l),
      .hit_r     (hit_r),
      .point_l   (point_l),
      .point_r   (point_r)
   );

   always_comb begin
      state_d     = state_q;
      xpos_d      = xpos_q;
      ypos_d      = ypos_q;
      dx_d        = dx_q;
      dy_d        = dy_q;
      speed_d     = speed_q;
      cnt_d       = cnt_q;
      score_l_d   = score_l_q;
      score_r_d   = score_r_q;
      game_over_d = game_over_q;
      winner_d    = winner_q;

      case (state_q)
         IDLE: begin
            // start takes priority; a coincident frame_tick is not counted.
            if (bus.start) begin
               state_d = SERVE;
               cnt_d   = '0;
            end
         end

         SERVE: begin
            if (bus.frame_tick) begin
               if (cnt_q == CNT_LAST) begin
                  cnt_d   = '0;
                  state_d = PLAY;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end

         PLAY: begin
            if (bus.frame_tick) begin
               xpos_d = step_x;
               ypos_d = step_y;
               dx_d   = step_dx;
               dy_d   = step_dy;
               if (hit_l || hit_r) speed_d = step_speed;

               if (point_l || point_r) begin
                  xpos_d  = XC;
                  ypos_d  = YC;
                  speed_d = SPD_SERVE;
                  dy_d    = (dy_q == DIR_POS) ? DIR_NEG : DIR_POS;
                  cnt_d   = '0;
                  state_d = SERVE;
                  if (point_l) begin
                     // Serve toward the right player, who conceded.
                     score_l_d = score_l_q + 1'b1;
                     dx_d      = DIR_POS;
                     if (score_l_d == SCORE_END) begin
                        state_d     = GAME_OVER;
                        game_over_d = 1'b1;
                        winner_d    = 1'b0;
                     end
                  end else begin
                     score_r_d = score_r_q + 1'b1;
                     dx_d      = DIR_NEG;
                     if (score_r_d == SCORE_END) begin
                        state_d     = GAME_OVER;
                        game_over_d = 1'b1;
                        winner_d    = 1'b1;
                     end
                  end
               end
            end
         end

         GAME_OVER: begin
            if (bus.start) begin
               score_l_d   = '0;
               score_r_d   = '0;
               dx_d        = DIR_POS;
               dy_d        = DIR_POS;
               game_over_d = 1'b0;
               cnt_d       = '0;
               state_d     = SERVE;
            end
         end

         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         xpos_q      <= XC;
         ypos_q      <= YC;
         dx_q        <= DIR_POS;
         dy_q        <= DIR_POS;
         speed_q     <= SPD_SERVE;
         cnt_q       <= '0;
         score_l_q   <= '0;
         score_r_q   <= '0;
         game_over_q <= 1'b0;
         winner_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         xpos_q      <= xpos_d;
         ypos_q      <= ypos_d;
         dx_q        <= dx_d;
         dy_q        <= dy_d;
         speed_q     <= speed_d;
         cnt_q       <= cnt_d;
         score_l_q   <= score_l_d;
         score_r_q   <= score_r_d;
         game_over_q <= game_over_d;
         winner_q    <= winner_d;
      end
   end

   assign bus.xpos      = xpos_q;
   assign bus.ypos      = ypos_q;
   assign bus.score_l   = score_l_q;
   assign bus.score_r   = score_r_q;
   assign bus.game_over = game_over_q;
   assign bus.winner    = winner_q;

endmodule

// File: tb/tb_pong_ball_engine.sv
// Scoreboard bench for pong_ball_engine: each frame tick pushes the expected
// post-tick outputs (from a small behavioural model of the game) into a
// queue; a monitor pops and compares one cycle after every tick. Directed
// spot checks with hand-derived constants cover reset, serve timing, the
// bottom wall, the right paddle hit, speed saturation, scoring and game over.
module tb_pong_ball_engine;

   localparam int M_IDLE = 0, M_SERVE = 1, M_PLAY = 2, M_GO = 3;

   typedef struct {
      int x;
      int y;
      int sl;
      int sr;
      int go;
      int win;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic resp_due = 1'b0;

   pong_ball_engine_if #(.SCORE_W(4)) bus ();

   pong_ball_engine #(.SCORE_W(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) resp_due <= bus.frame_tick;

   exp_t sb[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   bit   miss_right = 1'b0;

   // model state
   int m_state, m_x, m_y, m_spd, m_cnt, m_sl, m_sr, m_go, m_win, m_hits;
   bit m_dxr, m_dyd;

   task automatic chk(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_state = M_IDLE; m_x = 392; m_y = 292; m_spd = 2; m_cnt = 0;
      m_sl = 0; m_sr = 0; m_go = 0; m_win = 0; m_hits = 0;
      m_dxr = 1'b1; m_dyd = 1'b1;
   endtask

   task automatic model_step(input bit st, input bit tk, input int pl, input int pr);
      int xn, yn;
      bit hl, hr, dyd_old, left_scored;
      if (st && m_state == M_IDLE) begin
         m_state = M_SERVE; m_cnt = 0;
         return;
      end
      if (st && m_state == M_GO) begin
         m_sl = 0; m_sr = 0; m_dxr = 1'b1; m_dyd = 1'b1; m_go = 0;
         m_state = M_SERVE; m_cnt = 0;
         return;
      end
      if (!tk) return;
      if (m_state == M_SERVE) begin
         m_cnt++;
         if (m_cnt == 60) begin
            m_cnt = 0; m_state = M_PLAY;
         end
      end else if (m_state == M_PLAY) begin
         xn = m_dxr ? m_x + m_spd : m_x - m_spd;
         yn = m_dyd ? m_y + 2 : m_y - 2;
         hl = !m_dxr && m_x >= 30 && xn <= 30 && (m_y + 16 > pl) && (m_y < pl + 80);
         hr = m_dxr && m_x <= 754 && xn >= 754 && (m_y + 16 > pr) && (m_y < pr + 80);
         dyd_old = m_dyd;
         if (yn <= 0) begin
            m_y = 0; m_dyd = 1'b1;
         end else if (yn >= 584) begin
            m_y = 584; m_dyd = 1'b0;
         end else begin
            m_y = yn;
         end
         if (hl) begin
            m_x = 30; m_dxr = 1'b1; m_spd = (m_spd >= 8) ? 8 : m_spd + 1; m_hits++;
         end else if (hr) begin
            m_x = 754; m_dxr = 1'b0; m_spd = (m_spd >= 8) ? 8 : m_spd + 1; m_hits++;
         end else if (xn <= 0 || xn >= 784) begin
            left_scored = (xn >= 784);
            m_x = 392; m_y = 292; m_spd = 2;
            m_dyd = !dyd_old; m_dxr = left_scored;
            if (left_scored) m_sl++; else m_sr++;
            if (m_sl == 5 || m_sr == 5) begin
               m_state = M_GO; m_go = 1; m_win = left_scored ? 0 : 1;
            end else begin
               m_state = M_SERVE; m_cnt = 0;
            end
         end else begin
            m_x = xn;
         end
      end
   endtask

   task automatic do_tick(input bit with_start);
      int pl, pr;
      exp_t e;
      @(negedge clk);
      pl = (m_y >= 32) ? m_y - 32 : 0;
      if (miss_right) pr = (m_y >= 300) ? 0 : 400;
      else            pr = pl;
      bus.pad_l_y    = 11'(pl);
      bus.pad_r_y    = 11'(pr);
      bus.frame_tick = 1'b1;
      bus.start      = with_start;
      model_step(with_start, 1'b1, pl, pr);
      e.x = m_x; e.y = m_y; e.sl = m_sl; e.sr = m_sr; e.go = m_go; e.win = m_win;
      sb.push_back(e);
      @(negedge clk);
      bus.frame_tick = 1'b0;
      bus.start      = 1'b0;
   endtask

   task automatic do_start();
      @(negedge clk);
      bus.start = 1'b1;
      model_step(1'b1, 1'b0, 0, 0);
      @(negedge clk);
      bus.start = 1'b0;
   endtask

   // monitor: one response per frame tick
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (resp_due) begin
            if (sb.size() == 0) begin
               chk("sb_underflow", 1, 0);
            end else begin
               e = sb.pop_front();
               chk("sb_xpos",      int'(bus.xpos),      e.x);
               chk("sb_ypos",      int'(bus.ypos),      e.y);
               chk("sb_score_l",   int'(bus.score_l),   e.sl);
               chk("sb_score_r",   int'(bus.score_r),   e.sr);
               chk("sb_game_over", int'(bus.game_over), e.go);
               if (e.go != 0) chk("sb_winner", int'(bus.winner), e.win);
            end
         end
      end
   end

   initial begin
      bus.frame_tick = 1'b0;
      bus.start      = 1'b0;
      bus.pad_l_y    = '0;
      bus.pad_r_y    = '0;
      model_reset();

      // asynchronous reset, checked before any clock edge
      #3 rst = 1'b0;
      #1;
      chk("rst_xpos",      int'(bus.xpos),      392);
      chk("rst_ypos",      int'(bus.ypos),      292);
      chk("rst_score_l",   int'(bus.score_l),   0);
      chk("rst_score_r",   int'(bus.score_r),   0);
      chk("rst_game_over", int'(bus.game_over), 0);
      chk("rst_winner",    int'(bus.winner),    0);
      @(negedge clk);
      rst = 1'b1;

      // IDLE ignores ticks
      repeat (10) do_tick(1'b0);
      chk("idle_xpos", int'(bus.xpos), 392);
      chk("idle_ypos", int'(bus.ypos), 292);

      // start wins over a coincident tick; then 60 serve ticks
      do_tick(1'b1);
      repeat (30) do_tick(1'b0);
      do_start();                       // ignored in SERVE
      repeat (30) do_tick(1'b0);
      chk("serve_hold_x", int'(bus.xpos), 392);
      chk("serve_hold_y", int'(bus.ypos), 292);
      do_tick(1'b0);
      chk("first_move_x", int'(bus.xpos), 394);
      chk("first_move_y", int'(bus.ypos), 294);

      // rally with tracking paddles until speed has saturated
      for (int k = 2; k < 3000 && m_hits < 8; k++) begin
         if (k == 100) do_start();      // ignored in PLAY
         do_tick(1'b0);
         if (k == 145) chk("pre_wall_y",   int'(bus.ypos), 582);
         if (k == 146) chk("wall_clamp_y", int'(bus.ypos), 584);
         if (k == 147) chk("wall_back_y",  int'(bus.ypos), 582);
         if (k == 181) chk("rhit_x",       int'(bus.xpos), 754);
         if (k == 182) chk("rhit_speed3",  int'(bus.xpos), 751);
      end
      chk("hits_reached", m_hits, 8);
      do_tick(1'b0);
      chk("speed_sat_x", int'(bus.xpos), 38);

      // right paddle out of the way: left player scores
      miss_right = 1'b1;
      for (int i = 0; i < 400 && m_sl == 0; i++) do_tick(1'b0);
      chk("point_score_l", int'(bus.score_l), 1);
      chk("point_xpos",    int'(bus.xpos),    392);
      chk("point_ypos",    int'(bus.ypos),    292);
      repeat (60) do_tick(1'b0);
      do_tick(1'b0);
      chk("reserve_right", int'(bus.xpos), 394);

      for (int i = 0; i < 3000 && m_go == 0; i++) do_tick(1'b0);
      chk("go_flag",    int'(bus.game_over), 1);
      chk("go_winner",  int'(bus.winner),    0);
      chk("go_score_l", int'(bus.score_l),   5);
      repeat (5) do_tick(1'b0);
      chk("go_frozen_x", int'(bus.xpos), 392);

      // restart from GAME_OVER
      do_start();
      chk("restart_score_l", int'(bus.score_l),   0);
      chk("restart_go",      int'(bus.game_over), 0);
      miss_right = 1'b0;
      repeat (61) do_tick(1'b0);
      chk("restart_move_x", int'(bus.xpos), 394);
      repeat (19) do_tick(1'b0);
      chk("midplay_x", int'(bus.xpos), 432);

      // asynchronous reset in the middle of play
      @(posedge clk);
      #2 rst = 1'b0;
      #1;
      chk("midrst_xpos",      int'(bus.xpos),      392);
      chk("midrst_ypos",      int'(bus.ypos),      292);
      chk("midrst_score_l",   int'(bus.score_l),   0);
      chk("midrst_game_over", int'(bus.game_over), 0);
      model_reset();
      @(negedge clk);
      rst = 1'b1;
      repeat (3) do_tick(1'b0);

      repeat (3) @(negedge clk);
      chk("sb_drained", sb.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
